lsu: RTL and testbench
======================

# lsu

Load/store unit for the single-clock RV32I core. Sits between execute and write-back: takes the decoded `L_type`/`S_type` strobes, `funct3`, and the ALU-computed address. Runs a valid/ready transaction on the external data bus, stalling the PC while it is in flight. Returns the aligned, sign/zero-extended load word on `data_men_dout` for the write-back mux.

## Interface
Parameters:
- `datawidth`, 32, data and address width; only 32 is supported.

Ports:
- `clk` in 1: core clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `L_type` in 1: current instruction is a load.
- `S_type` in 1: current instruction is a store.
- `funct3` in 3: access size and sign.
  - `000` b, `001` h, `010` w, `100` bu, `101` hu.
  - `011`, `110`, `111` are treated as w.
- `addr` in 32: byte address (ALU result).
- `store_data` in 32: rs2 value.
- `stall` out 1: hold PC and the current instruction.
- `data_men_dout` out 32: extended load result.
- `misalign_err` out 1: misaligned-access flag.
- `bus_req` out 1: bus request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word-aligned address, bits [1:0] = 0.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_be` out 4: byte enables.
- `bus_ready` in 1: slave accept/complete.
- `bus_rdata` in 32: read word, valid when `bus_req & bus_ready`.

## Operation
State machine: IDLE, REQ, DONE.

- **IDLE**
  - On `L_type | S_type`, latch `funct3`, `addr[1:0]`, the direction and the bus fields, then go to REQ.
  - If `L_type` and `S_type` are both high, the access is treated as a load.
- **REQ**
  - `bus_req`=1.
  - Leave for DONE on the edge where `bus_req & bus_ready`.
  - On a load, capture `bus_rdata` on that edge.
- **DONE**
  - One cycle, `stall`=0, so the PC advances on this edge.
  - Next state is IDLE unconditionally.

`stall` is combinational:
- `stall = (IDLE & (L_type|S_type) & ~err) | REQ`.
- Forced to 0 while `rst_n` is low.

Store lanes:
- b: `bus_be = 1 << addr[1:0]`; `bus_wdata` = byte replicated ×4.
- h: `bus_be = addr[1] ? 1100 : 0011`; `bus_wdata` = half replicated ×2.
- w: `bus_be = 1111`; `bus_wdata = store_data`.

Loads:
- Select the byte or half from `bus_rdata` using the latched `addr[1:0]`.
- Sign-extend for b/h; zero-extend for bu/hu; pass w unchanged.
- Write the result to `data_men_dout` on the completing edge.
- `data_men_dout` holds its value until the next load completes; stores and idle cycles do not change it.
- On a load, `bus_be` is driven 1111.

Bus rules:
- `bus_we`, `bus_addr`, `bus_wdata` and `bus_be` are registered.
- They must stay stable from REQ entry until the transfer completes.
- `bus_req` never deasserts before `bus_ready`.
- The unit issues no back-to-back request without an intervening DONE and IDLE.

## Timing
- Reset values: `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_be`=0, `data_men_dout`=0, `misalign_err`=0, state IDLE.
- Reset mid-transfer: `bus_req` drops asynchronously; the access is abandoned and never replayed.
- Latency with `bus_ready` tied high:
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: REQ, transfer completes.
  - Cycle 2: DONE, data valid, `stall`=0.
  - Total 3 cycles per access.
- Each extra cycle `bus_ready` is low in REQ adds one stall cycle; there is no timeout.
- A non-memory instruction in IDLE costs zero cycles: `stall`=0 and no bus activity.

## Configuration
`LSU_MISALIGN_TRAP_EN` controls misaligned accesses: a half with `addr[0]`=1, or a word with `addr[1:0]`≠0.

- **Defined:**
  - A misaligned access issues no bus transaction.
  - IDLE goes directly to DONE with `misalign_err`=1 for that single cycle and `stall`=0.
  - `data_men_dout` is unchanged.
- **Undefined:**
  - The address is aligned down (half clears bit 0, word clears bits 1:0) and the access proceeds normally.
  - `misalign_err` is tied 0.

## Test plan
- lb at `addr=0x103`, `bus_rdata=0x80FF_1234`, ready high → `bus_addr=0x100`, `bus_be=1111`, `data_men_dout=0xFFFF_FF80`; `stall` high for exactly 2 cycles.
- lhu at `0x202`, `bus_rdata=0xBEEF_0000` → `data_men_dout=0x0000_BEEF`; lh at the same address → `0xFFFF_BEEF`.
- sb at `0x301`, `store_data=0x0000_00A5` → `bus_we`=1, `bus_be=0010`, `bus_wdata=0xA5A5_A5A5`; sh at `0x302` → `bus_be=1100`; `data_men_dout` unchanged.
- sw with `bus_ready` held low 4 cycles in REQ → `bus_*` stable throughout, `stall` high 6 cycles total, one completed transfer.
- lw at `0x006`:
  - With `LSU_MISALIGN_TRAP_EN` → no `bus_req`, `misalign_err` pulses 1 cycle, `stall` stays 0.
  - Without it → `bus_addr=0x004`, normal load.
- `rst_n` low while in REQ → `bus_req`=0 immediately, all outputs at reset values, state IDLE after release.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: one valid/ready bus transfer per load/store, PC stalled while in flight.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned h/w accesses skip the bus and flag misalign_err.
module lsu #(
  parameter int datawidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 L_type,
  input  logic                 S_type,
  input  logic [2:0]           funct3,
  input  logic [datawidth-1:0] addr,
  input  logic [datawidth-1:0] store_data,
  output logic                 stall,
  output logic [datawidth-1:0] data_men_dout,
  output logic                 misalign_err,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [datawidth-1:0] bus_addr,
  output logic [datawidth-1:0] bus_wdata,
  output logic [3:0]           bus_be,
  input  logic                 bus_ready,
  input  logic [datawidth-1:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e               state_q;
  logic [2:0]           f3_q;
  logic [1:0]           off_q;
  logic                 we_q, err_q;
  logic [datawidth-1:0] addr_q, wdata_q, dout_q;
  logic [3:0]           be_q;

  logic                 mem, is_b, is_h, err;
  logic [1:0]           off_d;
  logic [3:0]           be_d;
  logic [datawidth-1:0] wdata_d, ld_val;
  logic [7:0]           ld_b;
  logic [15:0]          ld_h;

  // 011/110/111 fall through to word size
  assign mem  = L_type | S_type;
  assign is_b = (funct3[1:0] == 2'b00);
  assign is_h = (funct3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  assign err = (is_h & addr[0]) | (~is_b & ~is_h & (addr[1:0] != 2'b00));
`else
  assign err = 1'b0;
`endif

  // Effective byte offset: misaligned halves/words are aligned down
  assign off_d   = is_b ? addr[1:0] : is_h ? {addr[1], 1'b0} : 2'b00;
  assign be_d    = L_type ? 4'b1111 :
                   is_b   ? (4'b0001 << off_d) :
                   is_h   ? (off_d[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_d = is_b ? {4{store_data[7:0]}} :
                   is_h ? {2{store_data[15:0]}} : store_data;

  always_comb begin
    ld_b   = bus_rdata[{off_q, 3'b000} +: 8];
    ld_h   = bus_rdata[{off_q[1], 4'b0000} +: 16];
    ld_val = bus_rdata;
    case (f3_q[1:0])
      2'b00:   ld_val = {{24{~f3_q[2] & ld_b[7]}}, ld_b};
      2'b01:   ld_val = {{16{~f3_q[2] & ld_h[15]}}, ld_h};
      default: ld_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (mem) begin
          if (err) begin
            state_q <= DONE;
            err_q   <= 1'b1;
          end else begin
            state_q <= REQ;
            f3_q    <= funct3;
            off_q   <= off_d;
            we_q    <= ~L_type;
            addr_q  <= {addr[datawidth-1:2], 2'b00};
            wdata_q <= wdata_d;
            be_q    <= be_d;
          end
        end
        REQ: if (bus_ready) begin
          state_q <= DONE;
          if (!we_q) dout_q <= ld_val;
        end
        default: begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign stall         = rst_n & (((state_q == IDLE) & mem & ~err) | (state_q == REQ));
  assign bus_req       = (state_q == REQ);
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_be        = be_q;
  assign data_men_dout = dout_q;
  assign misalign_err  = err_q;
endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: each access is predicted from size/offset arithmetic and checked cycle by cycle.
module tb_lsu;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        L_type = 1'b0, S_type = 1'b0, bus_ready = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, store_data = '0, bus_rdata = '0;
  logic        stall, misalign_err, bus_req, bus_we;
  logic [31:0] data_men_dout, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int checks = 0, errors = 0;
  logic [31:0] model_dout = '0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  lsu #(.datawidth(32)) dut (
    .clk(clk), .rst_n(rst_n), .L_type(L_type), .S_type(S_type), .funct3(funct3),
    .addr(addr), .store_data(store_data), .stall(stall), .data_men_dout(data_men_dout),
    .misalign_err(misalign_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic access(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int nwait);
    int          sz, stalls;
    bit          uns, trap;
    logic [31:0] ea, ewd, mask, ev;
    logic [3:0]  ebe;
    sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    uns  = f3[2] && sz < 4;
    trap = TRAP && (a % sz) != 0;
    ea   = a - (a % sz);
    ebe  = ld ? 4'hF : 4'(((1 << sz) - 1) << ea[1:0]);
    ewd  = (sz == 1) ? sd[7:0] * 32'h0101_0101 : (sz == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    ev   = (rd >> (8 * ea[1:0])) & mask;
    if (!uns && sz < 4 && ev[8*sz-1]) ev = ev | ~mask;

    @(negedge clk);
    L_type = ld; S_type = st; funct3 = f3; addr = a; store_data = sd;
    bus_ready = 1'b0; bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("idle_req", bus_req, 0);
    if (trap) begin
      chk("trap_idle_stall", stall, 0);
      @(negedge clk); L_type = 0; S_type = 0; #1;
      chk("trap_err", misalign_err, 1);
      chk("trap_stall", stall, 0);
      chk("trap_req", bus_req, 0);
      chk("trap_dout", data_men_dout, model_dout);
      @(negedge clk); #1;
      chk("trap_err_clr", misalign_err, 0);
      return;
    end
    chk("idle_stall", stall, 1);
    stalls = int'(stall);
    for (int k = 0; k <= nwait; k++) begin
      @(negedge clk);
      bus_ready = (k == nwait); bus_rdata = rd; #1;
      stalls += int'(stall);
      chk("req", bus_req, 1);
      chk("addr", bus_addr, {a[31:2], 2'b00});
      chk("we", bus_we, {31'd0, st & ~ld});
      chk("be", bus_be, ebe);
      if (st && !ld) chk("wdata", bus_wdata, ewd);
    end
    @(negedge clk);
    bus_ready = 1'b0; bus_rdata = 32'hDEAD_BEEF; #1;
    stalls += int'(stall);
    if (ld) model_dout = ev;
    chk("done_stall", stall, 0);
    chk("done_req", bus_req, 0);
    chk("dout", data_men_dout, model_dout);
    chk("stall_cycles", 32'(stalls), 32'(nwait + 2));
    @(negedge clk);
    L_type = 0; S_type = 0; #1;
    chk("post_stall", stall, 0);
    chk("post_dout", data_men_dout, model_dout);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_dout", data_men_dout, 0);
    chk("rst_err", misalign_err, 0);
    @(negedge clk); rst_n = 1'b1;

    // Non-memory instructions: no stall, no bus activity
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); addr = $urandom; funct3 = 3'($urandom); #1;
      chk("nomem_stall", stall, 0);
      chk("nomem_req", bus_req, 0);
    end

    access(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0); // lb
    access(1, 0, 3'b101, 32'h0000_0202, 32'h0, 32'hBEEF_0000, 0); // lhu
    access(1, 0, 3'b001, 32'h0000_0202, 32'h0, 32'hBEEF_0000, 0); // lh
    access(0, 1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0, 0); // sb
    access(0, 1, 3'b001, 32'h0000_0302, 32'h1234_5678, 32'h0, 0); // sh
    access(0, 1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, 4); // sw, slow slave
    access(1, 0, 3'b010, 32'h0000_0006, 32'h0, 32'h1357_9BDF, 0); // misaligned lw
    access(1, 1, 3'b100, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0000_C300, 1); // both strobes: load

    for (int i = 0; i < 150; i++) begin
      bit ld, st;
      ld = 1'($urandom_range(0, 1));
      st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
      access(ld, st, 3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    // Reset while a load waits in REQ: abandoned, outputs back to reset values
    @(negedge clk);
    L_type = 1; S_type = 0; funct3 = 3'b010; addr = 32'h0000_0040; bus_ready = 0;
    @(negedge clk); #1;
    chk("mid_req", bus_req, 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_req", bus_req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_dout", data_men_dout, 0);
    chk("mid_rst_be", bus_be, 0);
    chk("mid_rst_addr", bus_addr, 0);
    model_dout = '0;
    L_type = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("after_rst_stall", stall, 0);
    chk("after_rst_req", bus_req, 0);
    access(1, 0, 3'b001, 32'h0000_0052, 32'h0, 32'h7FFF_0001, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
